muldiv_iter_unit: RTL and testbench
===================================

Name: muldiv_iter_unit

Overview:
- Multi-cycle RV32M execution unit that takes the multiply/divide operations off the single-cycle ALU path.
- The EX stage issues an M-extension op with operands.
- The unit iterates 32 cycles and returns one registered 32-bit result with a valid pulse.
- The pipeline stalls on READY low and uses FLUSH to kill an in-flight op on branch/trap.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).
- ITER_CNT_W, 6, width of iteration counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  issue request; sampled only when READY=1.
- ALU_OPCODE  input  5  op select; `MUL/`MULH/`MULHSU/`MULHU/`DIV/`DIVU/`REM/`REMU encodings from definitions.v.
- DATA1  input  32  rs1 operand.
- DATA2  input  32  rs2 operand.
- FLUSH  input  1  abort in-flight op.
- READY  output  1  high in IDLE; unit can accept START.
- RESULT_VALID  output  1  one-cycle pulse, RESULT is valid.
- RESULT  output  32  registered result; held until next RESULT_VALID.

Behaviour:
- Reset: state=IDLE, READY=1, RESULT_VALID=0, RESULT=0, counter=0, internal operand/acc regs=0. RESET mid-op discards the op, no RESULT_VALID.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE, accept (START=1, FLUSH=0, opcode is one of the 8 M ops):
  - Latch op, operand magnitudes and sign flags. Signedness: MUL/MULH/DIV/REM both signed; MULHSU DATA1 signed, DATA2 unsigned; MULHU/DIVU/REMU unsigned.
  - Set div-by-zero flag = (DATA2==0) for div ops; counter=0; go CALC.
- Non-M opcode with START: ignored, READY stays 1.
- CALC, one iteration per cycle, 32 cycles (counter 0..31, then FIX):
  - Mul: 64-bit shift-add of magnitudes.
  - Div: restoring shift-subtract of magnitudes giving 32-bit quotient and remainder.
- FIX, one cycle:
  - Negate product if the operand signs differ (signed ops only).
  - Negate quotient if sign1^sign2; remainder takes the dividend sign.
  - Select RESULT: MUL=prod[31:0]; MULH/MULHSU/MULHU=prod[63:32]; DIV/DIVU=quot; REM/REMU=rem.
  - Register RESULT, assert RESULT_VALID, go IDLE.
- Latency: accept edge = edge 0; RESULT_VALID high in the cycle after edge 33. READY is high in that same cycle, so a back-to-back START there is accepted.
- Div by zero (all div ops): quotient=0xFFFFFFFF, remainder=DATA1 unmodified (forced in FIX from the latched flag, not sign-corrected).
- Signed overflow, DIV/REM 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
- START while READY=0: ignored; in-flight op unaffected.
- FLUSH in CALC/FIX: next edge state=IDLE, no RESULT_VALID, RESULT keeps its old value.
- FLUSH with START in IDLE: FLUSH wins, op not accepted.
- FLUSH in the RESULT_VALID cycle: no effect (result already delivered).
- RESULT_VALID is never asserted for two consecutive cycles.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined: at accept, the following skip CALC and go straight to FIX:
  - div by zero
  - signed overflow
  - any multiply with an operand == 0
  - RESULT_VALID appears in the cycle after edge 1 (latency 1 vs 33). Results are identical to the full path.
- Undefined: every accepted op takes the full 33-edge latency.

Test Plan:
- MUL 0x00000007 x 0xFFFFFFFD -> RESULT=0xFFFFFFEB. RESULT_VALID single pulse after edge 33. READY low edges 1..32.
- High-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Divides on 0xFFFFFFF9 / 0x00000002:
  - DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
  - DIVU -> 0x7FFFFFFC; REMU -> 0x00000001.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0x00000000.
  - With MULDIV_EARLY_OUT_EN: each of these completes after edge 1.
- DIVU 100/7 started, FLUSH at edge 10 -> no RESULT_VALID, READY=1 from edge 11, RESULT unchanged. START with DIV during CALC is ignored.
- Back-to-back and reset:
  - START MUL 3x4 in the RESULT_VALID cycle of a prior op -> accepted, RESULT=0x0000000C 33 edges later.
  - RESET at edge 20 of an op -> all outputs return to reset values, no RESULT_VALID.

Source files
------------

// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring divide, one-cycle sign fix.
// Define MULDIV_EARLY_OUT_EN to let div-by-zero, signed overflow and zero-operand multiplies skip CALC.
module muldiv_iter_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ITER_CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      ALU_OPCODE,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            FLUSH,
    output logic            READY,
    output logic            RESULT_VALID,
    output logic [XLEN-1:0] RESULT
);

    // M-extension opcodes: 2'b10 prefix followed by the RV32M funct3
    localparam logic [2:0] F3Mul    = 3'd0;
    localparam logic [2:0] F3Mulh   = 3'd1;
    localparam logic [2:0] F3Mulhsu = 3'd2;
    localparam logic [2:0] F3Mulhu  = 3'd3;
    localparam logic [2:0] F3Div    = 3'd4;
    localparam logic [2:0] F3Divu   = 3'd5;
    localparam logic [2:0] F3Rem    = 3'd6;
    localparam logic [2:0] F3Remu   = 3'd7;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e                state_q, state_d;
    logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]            op_q, op_d;
    logic                  neg1_q, neg1_d;
    logic                  neg2_q, neg2_d;
    logic                  dz_q, dz_d;
    logic [XLEN-1:0]       acc_q, acc_d;
    logic [XLEN-1:0]       lo_q, lo_d;
    logic [XLEN-1:0]       mcand_q, mcand_d;
    logic [XLEN-1:0]       op1_q, op1_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic                  valid_q, valid_d;

    // Issue-side decode
    logic            is_m_op, is_div, sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;

    always_comb begin
        is_m_op = (ALU_OPCODE[4:3] == 2'b10);
        is_div  = ALU_OPCODE[2];
        sgn1    = 1'b0;
        sgn2    = 1'b0;
        case (ALU_OPCODE[2:0])
            F3Mul, F3Mulh, F3Div, F3Rem: begin
                sgn1 = 1'b1;
                sgn2 = 1'b1;
            end
            F3Mulhsu: sgn1 = 1'b1;
            default:  ;
        endcase
        neg1 = sgn1 & DATA1[XLEN-1];
        neg2 = sgn2 & DATA2[XLEN-1];
        mag1 = neg1 ? -DATA1 : DATA1;
        mag2 = neg2 ? -DATA2 : DATA2;
    end

    logic early_out;
`ifdef MULDIV_EARLY_OUT_EN
    logic ovf_in;
    // sgn1 & is_div picks out DIV/REM
    assign ovf_in    = sgn1 & is_div & (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) & (DATA2 == '1);
    assign early_out = is_div ? ((DATA2 == '0) | ovf_in) : ((DATA1 == '0) | (DATA2 == '0));
`else
    assign early_out = 1'b0;
`endif

    // One shift-add multiply step on {acc, lo}; lo starts as the multiplier
    logic [XLEN-1:0] mul_addend;
    logic [XLEN:0]   mul_sum;
    // One restoring divide step; lo starts as the dividend and fills with quotient bits
    logic [XLEN:0]   div_shift, div_diff;
    logic            div_ge;

    always_comb begin
        mul_addend = lo_q[0] ? mcand_q : '0;
        mul_sum    = {1'b0, acc_q} + {1'b0, mul_addend};
        div_shift  = {acc_q, lo_q[XLEN-1]};
        div_diff   = div_shift - {1'b0, mcand_q};
        div_ge     = ~div_diff[XLEN];
    end

    // Sign correction and result selection
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

    always_comb begin
        prod     = {acc_q, lo_q};
        prod_fix = (neg1_q ^ neg2_q) ? -prod : prod;
        quot_fix = dz_q ? '1    : ((neg1_q ^ neg2_q) ? -lo_q : lo_q);
        rem_fix  = dz_q ? op1_q : (neg1_q ? -acc_q : acc_q);
        case (op_q)
            F3Mul:                     fix_result = prod_fix[XLEN-1:0];
            F3Mulh, F3Mulhsu, F3Mulhu: fix_result = prod_fix[2*XLEN-1:XLEN];
            F3Div, F3Divu:             fix_result = quot_fix;
            F3Rem, F3Remu:             fix_result = rem_fix;
            default:                   fix_result = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        dz_d     = dz_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        op1_d    = op1_q;
        result_d = result_q;
        valid_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (START && !FLUSH && is_m_op) begin
                    op_d    = ALU_OPCODE[2:0];
                    neg1_d  = neg1;
                    neg2_d  = neg2;
                    dz_d    = is_div & (DATA2 == '0);
                    cnt_d   = '0;
                    acc_d   = '0;
                    op1_d   = DATA1;
                    mcand_d = is_div ? mag2 : mag1;
                    // A skipped multiply has a zero operand, so its product is zero
                    lo_d    = is_div ? mag1 : (early_out ? '0 : mag2);
                    state_d = early_out ? StFix : StCalc;
                end
            end
            StCalc: begin
                if (FLUSH) begin
                    state_d = StIdle;
                end else begin
                    if (op_q[2]) begin
                        acc_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                        lo_d  = {lo_q[XLEN-2:0], div_ge};
                    end else begin
                        acc_d = mul_sum[XLEN:1];
                        lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + ITER_CNT_W'(1);
                    if (cnt_q == ITER_CNT_W'(XLEN - 1)) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!FLUSH) begin
                    result_d = fix_result;
                    valid_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            dz_q     <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            op1_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            dz_q     <= dz_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            op1_q    <= op1_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign READY        = (state_q == StIdle);
    assign RESULT_VALID = valid_q;
    assign RESULT       = result_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Self-checking bench for muldiv_iter_unit: directed RV32M cases, random ops against an
// arithmetic reference model, flush/reset/back-to-back control scenarios.
module tb_muldiv_iter_unit;

    localparam logic [4:0] OpMul    = 5'h10;
    localparam logic [4:0] OpMulh   = 5'h11;
    localparam logic [4:0] OpMulhsu = 5'h12;
    localparam logic [4:0] OpMulhu  = 5'h13;
    localparam logic [4:0] OpDiv    = 5'h14;
    localparam logic [4:0] OpDivu   = 5'h15;
    localparam logic [4:0] OpRem    = 5'h16;
    localparam logic [4:0] OpRemu   = 5'h17;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit Early = 1'b1;
`else
    localparam bit Early = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET, START, FLUSH;
    logic [4:0]  ALU_OPCODE;
    logic [31:0] DATA1, DATA2;
    logic        READY, RESULT_VALID;
    logic [31:0] RESULT;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_iter_unit dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .START        (START),
        .ALU_OPCODE   (ALU_OPCODE),
        .DATA1        (DATA1),
        .DATA2        (DATA2),
        .FLUSH        (FLUSH),
        .READY        (READY),
        .RESULT_VALID (RESULT_VALID),
        .RESULT       (RESULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    // Reference result from plain signed/unsigned arithmetic
    function automatic logic [31:0] ref_model(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        int          ia = a;
        int          ib = b;
        longint      sa = ia;
        longint      sb = ib;
        longint      ub = {32'b0, b};
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OpMul:    begin p = sa * sb; return p[31:0]; end
            OpMulh:   begin p = sa * sb; return p[63:32]; end
            OpMulhsu: begin p = sa * ub; return p[63:32]; end
            OpMulhu:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            OpDiv:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
            OpRem:    return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
            OpDivu:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        logic special;
        if (op[2]) special = (b == 0) ||
            ((op == OpDiv || op == OpRem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        else       special = (a == 0) || (b == 0);
        return (Early && special) ? 1 : 33;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All bench activity sits 1 time unit after a rising edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        START      = 1'b1;
        ALU_OPCODE = op;
        DATA1      = a;
        DATA2      = b;
        step();
        START      = 1'b0;
    endtask

    // Called after the accept edge plus 'elapsed' further edges; returns in the valid cycle
    task automatic wait_result(input string tag, input logic [31:0] exp, input int lat,
                               input int elapsed);
        int seen      = 0;
        int ready_bad = 0;
        if (READY) ready_bad++;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (RESULT_VALID) begin
                seen = elapsed + i;
                break;
            end
            if (READY) ready_bad++;
        end
        check({tag, "_latency"}, 32'(seen), 32'(lat));
        check({tag, "_result"}, RESULT, exp);
        check({tag, "_ready_busy"}, 32'(ready_bad), 32'd0);
        check({tag, "_ready_done"}, 32'(READY), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        issue(op, a, b);
        wait_result(tag, exp, exp_lat(op, a, b), 0);
        step();
        check({tag, "_pulse"}, 32'(RESULT_VALID), 32'd0);
    endtask

    task automatic watch_no_valid(input string tag, input int n);
        int cnt = 0;
        repeat (n) begin
            step();
            if (RESULT_VALID) cnt++;
        end
        check(tag, 32'(cnt), 32'd0);
    endtask

    vec_t dir [12];

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;

        dir[0]  = '{OpMul,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        dir[1]  = '{OpMulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        dir[2]  = '{OpMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        dir[3]  = '{OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        dir[4]  = '{OpDiv,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        dir[5]  = '{OpRem,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        dir[6]  = '{OpDivu,   32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC};
        dir[7]  = '{OpRemu,   32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001};
        dir[8]  = '{OpDiv,    32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
        dir[9]  = '{OpRemu,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
        dir[10] = '{OpDiv,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        dir[11] = '{OpRem,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

        RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
        ALU_OPCODE = '0; DATA1 = '0; DATA2 = '0;
        step();
        step();
        check("reset_ready", 32'(READY), 32'd1);
        check("reset_valid", 32'(RESULT_VALID), 32'd0);
        check("reset_result", RESULT, 32'h0);
        RESET = 1'b0;
        step();

        foreach (dir[i]) run_op($sformatf("dir%0d", i), dir[i].op, dir[i].a, dir[i].b, dir[i].exp);

        for (int i = 0; i < 40; i++) begin
            op = OpMul + 5'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: a = 0;
                2: b = 32'($urandom_range(1, 15));
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_op($sformatf("rnd%0d_op%0h_%08h_%08h", i, op, a, b), op, a, b, ref_model(op, a, b));
        end

        // Non-M opcode is ignored
        issue(5'h03, 32'd9, 32'd9);
        check("nonm_ready", 32'(READY), 32'd1);
        watch_no_valid("nonm_no_valid", 40);

        // START while busy does not disturb the in-flight op
        issue(OpDivu, 32'd100, 32'd7);
        repeat (4) step();
        issue(OpDiv, 32'd5, 32'd0);
        wait_result("busy_start", 32'd14, 33, 5);
        step();

        // FLUSH during CALC kills the op and keeps the old RESULT
        issue(OpDivu, 32'd100, 32'd7);
        repeat (9) step();
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        check("flush_ready", 32'(READY), 32'd1);
        step();
        check("flush_ready_next", 32'(READY), 32'd1);
        watch_no_valid("flush_no_valid", 40);
        check("flush_result_kept", RESULT, 32'd14);

        // FLUSH with START in IDLE: not accepted
        FLUSH = 1'b1;
        issue(OpMul, 32'd3, 32'd4);
        FLUSH = 1'b0;
        check("flush_start_ready", 32'(READY), 32'd1);
        watch_no_valid("flush_start_no_valid", 40);
        check("flush_start_result", RESULT, 32'd14);

        // FLUSH in the valid cycle has no effect
        issue(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("vflush", 32'hFFFF_FFFE, 33, 0);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        check("vflush_hold", RESULT, 32'hFFFF_FFFE);
        check("vflush_pulse", 32'(RESULT_VALID), 32'd0);

        // Back-to-back issue in the RESULT_VALID cycle
        issue(OpMul, 32'd7, 32'd5);
        wait_result("b2b_first", 32'd35, 33, 0);
        issue(OpMul, 32'd3, 32'd4);
        wait_result("b2b_second", 32'h0000_000C, 33, 0);
        step();
        check("b2b_pulse", 32'(RESULT_VALID), 32'd0);

        // RESET mid-op
        issue(OpDiv, 32'd1000, 32'd3);
        repeat (19) step();
        RESET = 1'b1;
        step();
        check("rst_mid_ready", 32'(READY), 32'd1);
        check("rst_mid_valid", 32'(RESULT_VALID), 32'd0);
        check("rst_mid_result", RESULT, 32'h0);
        RESET = 1'b0;
        watch_no_valid("rst_mid_no_valid", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
